// File: rtl/rv_decode_pkg.sv
// Shared decode constants for the RV32 decode stage: opcodes, function
// fields, one-hot flag bit positions and controller state encodings.
package rv_decode_pkg;

    localparam int unsigned FLAG_W = 13;

    localparam int unsigned FLAG_ADD   = 0;
    localparam int unsigned FLAG_XOR   = 1;
    localparam int unsigned FLAG_SLT   = 2;
    localparam int unsigned FLAG_AUIPC = 3;
    localparam int unsigned FLAG_LUI   = 4;
    localparam int unsigned FLAG_ADDI  = 5;
    localparam int unsigned FLAG_LW    = 6;
    localparam int unsigned FLAG_ANDI  = 7;
    localparam int unsigned FLAG_SRAI  = 8;
    localparam int unsigned FLAG_BEQ   = 9;
    localparam int unsigned FLAG_JAL   = 10;
    localparam int unsigned FLAG_SW    = 11;
    localparam int unsigned FLAG_ABSV  = 12;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;

endpackage

// File: rtl/insn_flag_decoder.sv
// Combinational RV32 subset decoder: one-hot flags, illegal marker,
// register-field extraction and source-operand usage.
module insn_flag_decoder
    import rv_decode_pkg::*;
#(
    parameter logic [6:0] ABSV_OPCODE = 7'b0001011
) (
    input  logic [31:0]       instr,
    output logic [FLAG_W-1:0] flags,
    output logic              illegal,
    output logic              uses_rs1,
    output logic              uses_rs2,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    // Field split and flag decode of the presented instruction
    always_comb begin
        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        rs1   = instr[19:15];
        rs2   = instr[24:20];
        rd    = instr[11:7];
        flags = '0;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    case (f3)
                        F3_ADD:  flags[FLAG_ADD] = 1'b1;
                        F3_XOR:  flags[FLAG_XOR] = 1'b1;
                        F3_SLT:  flags[FLAG_SLT] = 1'b1;
                        default: ;
                    endcase
                end
            end
            OPC_AUIPC: flags[FLAG_AUIPC] = 1'b1;
            OPC_LUI:   flags[FLAG_LUI]   = 1'b1;
            OPC_JAL:   flags[FLAG_JAL]   = 1'b1;
            OPC_OPIMM: begin
                case (f3)
                    F3_ADD:  flags[FLAG_ADDI] = 1'b1;
                    F3_AND:  flags[FLAG_ANDI] = 1'b1;
                    F3_SR:   flags[FLAG_SRAI] = (f7 == F7_SRA);
                    default: ;
                endcase
            end
            OPC_LOAD:   flags[FLAG_LW]  = (f3 == F3_WORD);
            OPC_STORE:  flags[FLAG_SW]  = (f3 == F3_WORD);
            OPC_BRANCH: flags[FLAG_BEQ] = (f3 == F3_BEQ);
            default: ;
        endcase
        // ABSV opcode is a parameter, so it is matched outside the case
        if (opc == ABSV_OPCODE && f3 == 3'b000 && f7 == F7_ZERO) begin
            flags[FLAG_ABSV] = 1'b1;
        end
        illegal  = (flags == '0);
        uses_rs1 = !illegal && !flags[FLAG_LUI] && !flags[FLAG_AUIPC] && !flags[FLAG_JAL];
        uses_rs2 = flags[FLAG_ADD] | flags[FLAG_XOR] | flags[FLAG_SLT]
                 | flags[FLAG_BEQ] | flags[FLAG_SW];
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode-stage controller: one-entry IF/ID register, EX issue handshake,
// single-cycle load-use bubble insertion and flush handling.
module decode_stage_ctrl
    import rv_decode_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter logic [6:0]  ABSV_OPCODE = 7'b0001011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    output logic              if_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [FLAG_W-1:0] id_flags,
    output logic              id_illegal,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [1:0]        state_q, state_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [FLAG_W-1:0] id_flags_q, id_flags_d;
    logic              id_illegal_q, id_illegal_d;
    logic [4:0]        id_rd_q, id_rd_d;
    logic              ex_lw_q, ex_lw_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic [FLAG_W-1:0] dec_flags;
    logic              dec_illegal, dec_uses_rs1, dec_uses_rs2;
    logic [4:0]        dec_rs1, dec_rs2, dec_rd;
    logic              capture, issue, haz;

    insn_flag_decoder #(
        .ABSV_OPCODE(ABSV_OPCODE)
    ) u_dec (
        .instr    (if_instr),
        .flags    (dec_flags),
        .illegal  (dec_illegal),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd)
    );

    // Handshake, ex-tracking update, hazard check and next-state logic
    always_comb begin
        id_valid = (state_q == ST_FULL);
        if_ready = !flush && ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && ex_ready));
        capture  = if_valid && if_ready;
        issue    = id_valid && ex_ready && !flush;

        ex_lw_d = ex_lw_q;
        ex_rd_d = ex_rd_q;
        if (flush || (state_q == ST_BUBBLE)) begin
            ex_lw_d = 1'b0;
            ex_rd_d = '0;
        end else if (issue) begin
            ex_lw_d = id_flags_q[FLAG_LW];
            ex_rd_d = id_rd_q;
        end

        // Hazard compares against the tracking value this cycle's issue produces
        haz = ex_lw_d && (ex_rd_d != '0)
           && ((dec_uses_rs1 && (dec_rs1 == ex_rd_d)) || (dec_uses_rs2 && (dec_rs2 == ex_rd_d)));

        id_instr_d   = id_instr_q;
        id_flags_d   = id_flags_q;
        id_illegal_d = id_illegal_q;
        id_rd_d      = id_rd_q;
        if (capture) begin
            id_instr_d   = if_instr;
            id_flags_d   = dec_flags;
            id_illegal_d = dec_illegal;
            id_rd_d      = dec_rd;
        end

        bubble_cnt_d = bubble_cnt_q;
        if (capture && haz && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end

        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:  if (capture) state_d = haz ? ST_BUBBLE : ST_FULL;
                ST_FULL: begin
                    if (ex_ready) begin
                        if (capture) state_d = haz ? ST_BUBBLE : ST_FULL;
                        else         state_d = ST_EMPTY;
                    end
                end
                ST_BUBBLE: state_d = ST_FULL;
                default:   state_d = ST_EMPTY;
            endcase
        end

        id_instr   = id_instr_q;
        id_flags   = id_flags_q;
        id_illegal = id_illegal_q;
        bubble_cnt = bubble_cnt_q;
    end

    // State and pipeline register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            id_instr_q   <= '0;
            id_flags_q   <= '0;
            id_illegal_q <= 1'b0;
            id_rd_q      <= '0;
            ex_lw_q      <= 1'b0;
            ex_rd_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            id_instr_q   <= id_instr_d;
            id_flags_q   <= id_flags_d;
            id_illegal_q <= id_illegal_d;
            id_rd_q      <= id_rd_d;
            ex_lw_q      <= ex_lw_d;
            ex_rd_q      <= ex_rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Bench for decode_stage_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of the ID slot.
module tb_decode_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [12:0] id_flags;
    logic        id_illegal;
    logic [15:0] bubble_cnt;

    int total = 0;
    int bad = 0;
    int exp_bub = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_SRAI = 32'h4030D093; // srai x1,x1,3
    localparam logic [31:0] I_LW   = 32'h0000A103; // lw x2,0(x1)
    localparam logic [31:0] I_LW0  = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] I_XOR  = 32'h0020C233; // xor x4,x1,x2
    localparam logic [31:0] I_ADDI = 32'h00100293; // addi x5,x0,1

    // Encoding table indexed by flag bit: (instr & MASK) == MATCH
    logic [31:0] MASK [13] = '{32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'h0000007F,
                               32'h0000007F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
                               32'hFE00707F, 32'h0000707F, 32'h0000007F, 32'h0000707F,
                               32'hFE00707F};
    logic [31:0] MATCH [13] = '{32'h00000033, 32'h00004033, 32'h00002033, 32'h00000017,
                                32'h00000037, 32'h00000013, 32'h00002003, 32'h00007013,
                                32'h40005013, 32'h00000063, 32'h0000006F, 32'h00002023,
                                32'h0000000B};

    decode_stage_ctrl #(.CNT_W(16), .ABSV_OPCODE(7'b0001011)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_flags   (id_flags),
        .id_illegal (id_illegal),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic int model_idx(input logic [31:0] ins);
        for (int k = 0; k < 13; k++) begin
            if ((ins & MASK[k]) == MATCH[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] gen_instr();
        int unsigned k;
        logic [31:0] r;
        k = $urandom_range(0, 13);
        r = $urandom;
        if (k < 13) r = (r & ~MASK[k]) | MATCH[k];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_id_instr: got %h want 0", id_instr); end
        total++; if (id_flags !== 13'h0) begin bad++; $display("FAIL reset_id_flags: got %h want 0", id_flags); end
        total++; if (id_illegal !== 1'b0) begin bad++; $display("FAIL reset_id_illegal: got %b want 0", id_illegal); end
        total++; if (bubble_cnt !== 16'h0) begin bad++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_bub = 0;
    endtask

    task automatic test_decode_sweep();
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_ADD;
        step();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL sweep_add_valid: got %b want 1", id_valid); end
        total++; if (id_flags !== 13'h0001) begin bad++; $display("FAIL sweep_add_flags: got %h want 0001", id_flags); end
        total++; if (id_instr !== I_ADD) begin bad++; $display("FAIL sweep_add_instr: got %h want %h", id_instr, I_ADD); end
        if_instr = I_SRAI;
        step();
        total++; if (id_flags !== 13'h0100) begin bad++; $display("FAIL sweep_srai_flags: got %h want 0100", id_flags); end
        total++; if (id_illegal !== 1'b0) begin bad++; $display("FAIL sweep_srai_illegal: got %b want 0", id_illegal); end
        if_instr = 32'h0;
        step();
        total++; if (id_flags !== 13'h0) begin bad++; $display("FAIL sweep_zero_flags: got %h want 0", id_flags); end
        total++; if (id_illegal !== 1'b1) begin bad++; $display("FAIL sweep_zero_illegal: got %b want 1", id_illegal); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL sweep_zero_valid: got %b want 1", id_valid); end
        if_valid = 1'b0;
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL sweep_drain_valid: got %b want 0", id_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ins = {12'(i + 1), 5'd0, 3'b000, 5'(i + 5), 7'b0010011};
            if_valid = 1'b1;
            if_instr = ins;
            #1;
            total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL b2b_if_ready[%0d]: got %b want 1", i, if_ready); end
            step();
            total++; if (id_valid !== 1'b1 || id_instr !== ins) begin
                bad++; $display("FAIL b2b_issue[%0d]: got valid=%b instr=%h want valid=1 instr=%h", i, id_valid, id_instr, ins);
            end
        end
        if_valid = 1'b0;
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", id_valid); end
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_LW;
        step();
        total++; if (id_flags !== 13'h0040) begin bad++; $display("FAIL lu_lw_flags: got %h want 0040", id_flags); end
        if_instr = I_ADD;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL lu_accept: got %b want 1", if_ready); end
        step();
        exp_bub++;
        if_valid = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid: got %b want 0", id_valid); end
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL lu_bubble_ready: got %b want 0", if_ready); end
        total++; if (bubble_cnt !== 16'(exp_bub)) begin bad++; $display("FAIL lu_bubble_cnt: got %0d want %0d", bubble_cnt, exp_bub); end
        step();
        total++; if (id_valid !== 1'b1 || id_instr !== I_ADD) begin
            bad++; $display("FAIL lu_after_bubble: got valid=%b instr=%h want valid=1 instr=%h", id_valid, id_instr, I_ADD);
        end
        step();
        if_valid = 1'b1;
        if_instr = I_LW0;
        step();
        if_instr = I_ADD;
        step();
        if_valid = 1'b0;
        total++; if (id_valid !== 1'b1 || id_instr !== I_ADD) begin
            bad++; $display("FAIL lu_x0_nobubble: got valid=%b instr=%h want valid=1 instr=%h", id_valid, id_instr, I_ADD);
        end
        total++; if (bubble_cnt !== 16'(exp_bub)) begin bad++; $display("FAIL lu_x0_cnt: got %0d want %0d", bubble_cnt, exp_bub); end
        step();
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_ADD;
        step();
        ex_ready = 1'b0;
        if_instr = I_XOR;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL bp_if_ready[%0d]: got %b want 0", i, if_ready); end
            step();
            total++; if (id_valid !== 1'b1 || id_instr !== I_ADD || id_flags !== 13'h0001) begin
                bad++; $display("FAIL bp_hold[%0d]: got valid=%b instr=%h flags=%h want 1 %h 0001", i, id_valid, id_instr, id_flags, I_ADD);
            end
        end
        ex_ready = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", if_ready); end
        step();
        total++; if (id_valid !== 1'b1 || id_instr !== I_XOR || id_flags !== 13'h0002) begin
            bad++; $display("FAIL bp_next: got valid=%b instr=%h flags=%h want 1 %h 0002", id_valid, id_instr, id_flags, I_XOR);
        end
        if_valid = 1'b0;
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", id_valid); end
    endtask

    task automatic test_flush();
        // flush while FULL
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_ADD;
        step();
        flush = 1'b1;
        if_instr = I_XOR;
        #1;
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL fl_full_ready: got %b want 0", if_ready); end
        step();
        flush = 1'b0;
        if_valid = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            bad++; $display("FAIL fl_full_empty: got valid=%b ready=%b want 0 1", id_valid, if_ready);
        end
        // flush while BUBBLE
        if_valid = 1'b1;
        if_instr = I_LW;
        step();
        if_instr = I_ADD;
        step();
        exp_bub++;
        if_valid = 1'b0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fl_bub_enter: got %b want 0", id_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            bad++; $display("FAIL fl_bub_empty: got valid=%b ready=%b want 0 1", id_valid, if_ready);
        end
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fl_bub_stay: got %b want 0", id_valid); end
        // pending load hazard is forgotten by flush
        if_valid = 1'b1;
        if_instr = I_LW;
        step();
        if_instr = I_ADDI;
        step();
        ex_ready = 1'b0;
        flush = 1'b1;
        if_valid = 1'b0;
        step();
        flush = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_ADD;
        step();
        if_valid = 1'b0;
        total++; if (id_valid !== 1'b1 || id_instr !== I_ADD) begin
            bad++; $display("FAIL fl_haz_cleared: got valid=%b instr=%h want valid=1 instr=%h", id_valid, id_instr, I_ADD);
        end
        total++; if (bubble_cnt !== 16'(exp_bub)) begin bad++; $display("FAIL fl_cnt: got %0d want %0d", bubble_cnt, exp_bub); end
        step();
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = I_LW;
        step();
        if_instr = I_ADD;
        step();
        if_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_bub = 0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", id_valid); end
        total++; if (bubble_cnt !== 16'h0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", bubble_cnt); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL ar_ready: got %b want 1", if_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        if_valid = 1'b1;
        if_instr = I_ADD;
        step();
        if_valid = 1'b0;
        total++; if (id_valid !== 1'b1 || id_instr !== I_ADD || id_flags !== 13'h0001) begin
            bad++; $display("FAIL ar_first_capture: got valid=%b instr=%h flags=%h want 1 %h 0001", id_valid, id_instr, id_flags, I_ADD);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] slot [$];
        bit          slot_wait;
        int          load_rd;
        int          bub;
        int          idx;
        bit          e_valid, e_ready, cap, haz;
        logic [31:0] head, ins;
        logic [12:0] e_flags;
        // start from a clean reset so the model state is known
        if_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        slot_wait = 1'b0;
        load_rd = -1;
        bub = 0;
        for (int c = 0; c < 400; c++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if_instr = gen_instr();
            #1;
            e_valid = (slot.size() == 1) && !slot_wait;
            e_ready = !flush && ((slot.size() == 0) || (e_valid && ex_ready));
            total++; if (id_valid !== e_valid) begin bad++; $display("FAIL rnd_valid @%0d: got %b want %b", c, id_valid, e_valid); end
            total++; if (if_ready !== e_ready) begin bad++; $display("FAIL rnd_ready @%0d: got %b want %b", c, if_ready, e_ready); end
            total++; if (bubble_cnt !== 16'(bub)) begin bad++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", c, bubble_cnt, bub); end
            if (e_valid) begin
                head = slot[0];
                idx = model_idx(head);
                e_flags = (idx >= 0) ? 13'(1 << idx) : 13'h0;
                total++; if (id_instr !== head || id_flags !== e_flags || id_illegal !== (idx < 0)) begin
                    bad++; $display("FAIL rnd_payload @%0d: got %h/%h/%b want %h/%h/%b", c, id_instr, id_flags, id_illegal, head, e_flags, idx < 0);
                end
            end
            // advance the model across the coming clock edge
            cap = if_valid && e_ready;
            if (flush) begin
                slot.delete();
                slot_wait = 1'b0;
                load_rd = -1;
            end else begin
                if (slot.size() == 1 && slot_wait) begin
                    slot_wait = 1'b0;
                    load_rd = -1;
                end else if (e_valid && ex_ready) begin
                    head = slot.pop_front();
                    load_rd = (model_idx(head) == 6) ? int'(head[11:7]) : -1;
                end
                if (cap) begin
                    ins = if_instr;
                    idx = model_idx(ins);
                    haz = 1'b0;
                    if (load_rd > 0 && idx >= 0) begin
                        if (idx != 3 && idx != 4 && idx != 10 && int'(ins[19:15]) == load_rd) haz = 1'b1;
                        if ((idx == 0 || idx == 1 || idx == 2 || idx == 9 || idx == 11) && int'(ins[24:20]) == load_rd) haz = 1'b1;
                    end
                    slot.push_back(ins);
                    slot_wait = haz;
                    if (haz && bub < 65535) bub++;
                end
            end
            @(negedge clk);
        end
        if_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
